// File: rtl/mem_ctrl_if.sv
// CPU-side and RAM-side bus bundle for mem_ctrl.
// The slave modport is the controller; the master modport is the surrounding CPU/RAM environment.
interface mem_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  fcode;
    logic [31:0] r_addr;
    logic [31:0] w_addr;
    logic [31:0] w_line;
    logic        read;
    logic        write;
    logic [31:0] r_line;
    logic        rrdy;
    logic        wrdy;
    logic        exc;

    modport slave (
        input  req, we, addr, wdata, r_line, rrdy, wrdy, exc,
        output busy, ack, rdata, fault, fcode, r_addr, w_addr, w_line, read, write
    );

    modport master (
        output req, we, addr, wdata, r_line, rrdy, wrdy, exc,
        input  busy, ack, rdata, fault, fcode, r_addr, w_addr, w_line, read, write
    );
endinterface

// File: rtl/mem_ctrl.sv
// Single-access memory controller: CPU request -> one RAM read/write with alignment,
// range and timeout checking, reported by a one-cycle ack with a fault code.
module mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int TIMEOUT   = 16
) (
    input logic      clk,
    input logic      rst_n,
    mem_ctrl_if.slave bus
);
    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_WAIT = CW'(TIMEOUT - 1);
    localparam logic [31:0]    WORDS_W   = 32'(MEM_WORDS);

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ALIGN   = 2'd1;
    localparam logic [1:0] FC_RANGE   = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   widx_q, widx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    fcode_q, fcode_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic arming;
    logic resp;

    function automatic logic [31:0] word_index(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // First cycle in RD/WR carries stale ram handshakes, so responses are only honoured after it.
    assign arming = (cnt_q == '0);
    assign resp   = (state_q == RD) ? bus.rrdy : bus.wrdy;

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fcode_d = fcode_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    widx_d  = word_index(bus.addr);
                    wdata_d = bus.wdata;
                    cnt_d   = '0;
                    if (bus.addr[1:0] != 2'b00) begin
                        state_d = DONE;
                        fcode_d = FC_ALIGN;
                    end else if (word_index(bus.addr) >= WORDS_W) begin
                        state_d = DONE;
                        fcode_d = FC_RANGE;
                    end else begin
                        state_d = bus.we ? WR : RD;
                        fcode_d = FC_NONE;
                    end
                end
            end
            RD, WR: begin
                cnt_d = cnt_q + 1'b1;
                if (!arming && resp) begin
                    state_d = DONE;
                    fcode_d = FC_NONE;
                    if (state_q == RD) begin
                        rdata_d = bus.r_line;
                    end
                end else if (!arming && bus.exc) begin
                    state_d = DONE;
                    fcode_d = FC_RANGE;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = DONE;
                    fcode_d = FC_TIMEOUT;
                end
            end
            DONE: begin
                state_d = IDLE;
                fcode_d = FC_NONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            widx_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fcode_q <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fcode_q <= fcode_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state, so strobes drop as soon as reset asserts.
    assign bus.busy   = (state_q != IDLE);
    assign bus.ack    = (state_q == DONE);
    assign bus.fault  = (state_q == DONE) && (fcode_q != FC_NONE);
    assign bus.fcode  = (state_q == DONE) ? fcode_q : FC_NONE;
    assign bus.read   = (state_q == RD);
    assign bus.write  = (state_q == WR);
    assign bus.r_addr = widx_q;
    assign bus.w_addr = widx_q;
    assign bus.w_line = wdata_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words in the downstream ram; word index >= MEM_WORDS is out of range.
REQ-002 Parameter TIMEOUT, default 16: maximum wait cycles for rrdy/wrdy before a timeout fault.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req  in  1  CPU access request; sampled only in IDLE.
REQ-006 we  in  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  in  32  CPU byte address; sampled with req.
REQ-008 wdata  in  32  CPU write data; sampled with req.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 ack  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  read data; valid with ack, held until the next read completes.
REQ-012 fault  out  1  high with ack when the access failed.
REQ-013 fcode  out  2  fault cause with ack: 0 none, 1 misaligned, 2 range, 3 timeout.
REQ-014 r_addr  out  32  ram read word index = {2'b00, addr[31:2]}.
REQ-015 w_addr  out  32  ram write word index = {2'b00, addr[31:2]}.
REQ-016 w_line  out  32  ram write data.
REQ-017 read  out  1  ram read strobe.
REQ-018 write  out  1  ram write strobe.
REQ-019 r_line  in  32  ram read data; valid only while rrdy = 1.
REQ-020 rrdy  in  1  ram read done; one-cycle pulse.
REQ-021 wrdy  in  1  ram write done; one-cycle pulse.
REQ-022 exc  in  1  ram range exception; sticky until the next successful ram access.

Function
REQ-023 The FSM SHALL have four states: IDLE, RD, WR, DONE.
REQ-024 IDLE with req = 1 at an edge: the block SHALL latch addr, we and wdata, then select the next state as follows.
  - addr[1:0] != 0: DONE with fcode 1, no ram strobe.
  - Word index >= MEM_WORDS: DONE with fcode 2, no ram strobe.
  - Otherwise: RD if we = 0, WR if we = 1.
REQ-025 read SHALL be high exactly while in RD, and write exactly while in WR; both SHALL be registered, never combinational from req.
REQ-026 r_addr, w_addr and w_line SHALL be stable from entry into RD/WR until the state is left.
REQ-027 On the first clock edge in RD/WR, rrdy, wrdy and exc SHALL be ignored because they are stale; this first cycle is the arming cycle.
REQ-028 In RD after the arming cycle:
  - rrdy = 1: capture r_line into rdata, go to DONE with fcode 0.
  - Else exc = 1: go to DONE with fcode 2.
REQ-029 In WR after the arming cycle:
  - wrdy = 1: go to DONE with fcode 0.
  - Else exc = 1: go to DONE with fcode 2.
REQ-030 If rrdy/wrdy and exc are both high in the same cycle, rrdy/wrdy SHALL win.
REQ-031 A wait counter SHALL count cycles spent in RD/WR; when it reaches TIMEOUT with no response, the FSM SHALL go to DONE with fcode 3 and drop the strobe.
REQ-032 The wait counter width SHALL be $clog2(TIMEOUT+1), and the counter SHALL clear on every entry to RD/WR.
REQ-033 DONE SHALL last exactly one cycle with ack = 1, fault = (fcode != 0), then return to IDLE.
REQ-034 req during RD, WR or DONE SHALL be ignored; a req still high on return to IDLE SHALL start a new access at the next edge.
REQ-035 Nominal latency with an in-range, aligned access and a single-cycle ram:
  - req sampled at edge E0; strobe high after E0; ram responds at E1.
  - Controller sees rrdy/wrdy at E2; ack is high in the cycle after E2.
REQ-036 rdata SHALL NOT change on writes or on faulted accesses.
REQ-037 ack, fault and fcode SHALL be 0 outside DONE.

Reset
REQ-038 While rst_n = 0, the block SHALL hold these values immediately, independent of clk:
  - FSM in IDLE; read, write, ack, fault, busy = 0.
  - fcode = 0; rdata, r_addr, w_addr, w_line = 0; wait counter = 0.
REQ-039 Reset asserted mid-access SHALL abort the access, drop the strobe at once, and emit no ack.
REQ-040 The first req SHALL be accepted at the first clock edge after rst_n rises.

Verification
REQ-041 Read from addr 0x10 (ram word 4 = 0xDEADBEEF) -> r_addr = 4; read high for 2 cycles; ack after 3 cycles with rdata = 0xDEADBEEF, fault = 0.
REQ-042 Write 0x12345678 to addr 0x20, then read 0x20 -> w_addr = 8, wrdy seen, ack with fault = 0; the read returns 0x12345678.
REQ-043 Read from addr 0x13 -> no read strobe; ack next cycle with fault = 1, fcode = 1.
REQ-044 Read from addr 0x1000 (word 1024) -> no strobe, fcode = 2; a forced ram exc with rrdy = 0 on an in-range read -> fcode 2 after the arming cycle.
REQ-045 Stale exc = 1 held before an in-range read, ram returns rrdy -> fcode 0, correct data.
REQ-046 rrdy tied to 0 -> read held for 16 cycles, then ack with fcode 3; rst_n pulsed low mid-RD -> read = 0 at once, no ack.
